// File: rtl/npu_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between NUM_REQ requesters.
// One transaction in flight at a time; a hung access is turned into an error response.
module npu_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_rdata,
  output logic                           o_rsp_err,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic                           o_mem_we,
  output logic                           o_mem_re,
  input  logic                           i_mem_valid,
  output logic                           o_busy,
  output logic [ID_W-1:0]                o_grant_id,
  output logic [15:0]                    o_err_count
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [ID_W-1:0]       r_last, r_id, w_win;
  logic                  w_found, w_hs, w_done, w_tout;
  logic                  r_we, r_mem_re, r_mem_we, r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rsp_rdata;
  logic [TCNT_W-1:0]     r_tcnt;
  logic [15:0]           r_err_count;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_hs        = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    case (r_state)
      S_IDLE: if (w_found) begin
        o_req_ready[w_win] = 1'b1;
        w_hs   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_valid) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES-1)) begin
          w_tout = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid[r_id] = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last      <= ID_W'(NUM_REQ-1);
      r_id        <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tcnt      <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_hs) begin
        r_last   <= w_win;
        r_id     <= w_win;
        r_we     <= i_req_we[w_win];
        r_addr   <= i_req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata  <= i_req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_tcnt   <= '0;
        r_mem_re <= !i_req_we[w_win];
        r_mem_we <= i_req_we[w_win];
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      // Response payload is held until the next completion overwrites it.
      if (w_done || w_tout) begin
        r_mem_re    <= 1'b0;
        r_mem_we    <= 1'b0;
        r_rsp_rdata <= (w_done && !r_we) ? i_mem_rdata : '0;
        r_rsp_err   <= w_tout;
        if (w_tout && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = (r_state != S_IDLE);
  assign o_grant_id  = r_id;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Random traffic against a transaction-level model: each grant is tracked as
// (handshake cycle, completion cycle) and every output is predicted from that.
module tb_npu_mem_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TC = 16;
  localparam int IW = $clog2(NR);

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;
  logic             rsp_err, mem_we, mem_re, mem_valid, busy;
  logic [IW-1:0]    grant_id;
  logic [15:0]      err_count;

  npu_mem_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_valid(mem_valid),
    .o_busy(busy), .o_grant_id(grant_id), .o_err_count(err_count));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model state: one outstanding transaction described by its cycle stamps.
  bit          act, to, m_we, did_mid;
  int          t_hs, t_done, m_last, m_id, m_gid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit          m_err;
  int          m_ec;

  function automatic int winner(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic m_reset();
    act = 0; m_last = NR - 1; m_id = 0; m_gid = 0;
    m_rdata = '0; m_err = 0; m_ec = 0; m_we = 0;
  endtask

  initial begin
    bit in_wait, in_resp;
    int w, mode, d;
    logic [NR-1:0] e_ready, e_rsp;
    rst = 1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_valid = 0; mem_rdata = '0; did_mid = 0;
    t_hs = 0; t_done = 0; to = 0; m_addr = '0; m_wdata = '0;
    @(posedge clk); #1;
    m_reset();
    for (cyc = 0; cyc < 3000; cyc++) begin
      mode    = (cyc < 60) ? 0 : 1;
      in_wait = act && cyc >= t_hs + 1 && cyc <= t_done;
      in_resp = act && cyc == t_done + 1;

      if (cyc < 3) rst = 1;
      else if (mode == 1 && in_wait && !did_mid && cyc > 200) begin rst = 1; did_mid = 1; end
      else rst = (mode == 1 && $urandom_range(0, 299) == 0);
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        req_we[i]    = $urandom_range(0, 1);
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
      end
      mem_rdata = $urandom;
      if (!in_wait) mem_valid = ($urandom_range(0, 3) == 0);
      else          mem_valid = (!to && cyc == t_done);
      #1;

      w = act ? -1 : winner(m_last, req_valid);
      e_ready = '0;
      if (w >= 0) e_ready[w] = 1'b1;
      e_rsp = '0;
      if (in_resp) e_rsp[m_id] = 1'b1;
      chk("req_ready", req_ready, e_ready);
      chk("mem_re", mem_re, in_wait && !m_we);
      chk("mem_we", mem_we, in_wait && m_we);
      if (in_wait) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
      chk("busy", busy, act);
      chk("grant_id", grant_id, m_gid);
      chk("err_count", err_count, m_ec);

      if (rst) m_reset();
      else if (!act) begin
        if (w >= 0) begin
          act = 1; t_hs = cyc; m_id = w; m_last = w; m_gid = w;
          m_we = req_we[w]; m_addr = req_addr[w*AW +: AW]; m_wdata = req_wdata[w*DW +: DW];
          to = (mode == 1) && ($urandom_range(0, 7) == 0);
          d  = (mode == 1) ? $urandom_range(1, 6) : 1;
          t_done = to ? cyc + TC : cyc + d;
        end
      end else if (cyc == t_done) begin
        m_rdata = (to || m_we) ? '0 : mem_rdata;
        m_err   = to;
        if (to && m_ec != 16'hFFFF) m_ec++;
      end else if (cyc == t_done + 1) act = 0;

      @(posedge clk); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
